// File: rtl/mips_register_file.sv
// mips_register_file
//   32 x DATA_W MIPS general-purpose register file with two combinational
//   source-operand read ports (rs, rt), one synchronous write port fed by
//   the RegDst-selected index, a never-bypassed debug read port and
//   write-tracking state (per-register written mask, saturating counter).
//
//   Build option: define REGFILE_BYPASS_EN to forward write_data onto
//   read_data1/read_data2 when they address the register being written in
//   the same cycle. Without it the read ports return the stored (old) value.
//
//   Register 0 has no storage; it always reads as zero and writes to it are
//   dropped without touching the mask or the counter.

module mips_register_file #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_3FFC,
  parameter logic [DATA_W-1:0] GP_RESET = 32'h0000_1800,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [4:0]        dbg_reg,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       written_mask,
  output logic [CNT_W-1:0]  write_count
);

  localparam int GP_IDX = 28;
  localparam int SP_IDX = 29;

  // Storage for r1..r31 only; r0 is synthesised as a constant zero.
  logic [DATA_W-1:0] regs [1:31];

  logic              commit;
  logic [31:0]       write_onehot;
  logic              count_full;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;
  logic [DATA_W-1:0] stored_dbg;

  // Reset contents: $gp and $sp get their boot values, everything else zero.
  function automatic logic [DATA_W-1:0] reset_value(input int idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (idx == GP_IDX) val = GP_RESET;
    if (idx == SP_IDX) val = SP_RESET;
    return val;
  endfunction

  // Combinational lookup of a stored register; index 0 always yields zero.
  function automatic logic [DATA_W-1:0] lookup(input logic [4:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 1; i < 32; i++) begin
      if (idx == 5'(i)) val = regs[i];
    end
    return val;
  endfunction

  // A write commits only when enabled and not aimed at the zero register.
  always_comb begin
    commit       = regWrite && (write_reg != 5'd0);
    write_onehot = 32'd1 << write_reg;
  end

  // Register array: asynchronous reset to boot values, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= reset_value(i);
      end
    end else if (commit) begin
      for (int i = 1; i < 32; i++) begin
        if (write_reg == 5'(i)) regs[i] <= write_data;
      end
    end
  end

  // Sticky per-register written flags; bit 0 can never be set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_mask <= '0;
    end else if (commit) begin
      written_mask <= written_mask | write_onehot;
    end
  end

  // Committed-write counter, holds at all-ones instead of wrapping.
  assign count_full = &write_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_count <= '0;
    end else if (commit && !count_full) begin
      write_count <= write_count + CNT_W'(1);
    end
  end

  // Stored-value lookups for the two operand ports and the debug port.
  always_comb begin
    stored1    = lookup(read_reg1);
    stored2    = lookup(read_reg2);
    stored_dbg = lookup(dbg_reg);
  end

  // Debug port always shows what is actually held in the array.
  assign dbg_data = stored_dbg;

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  // Write-before-read: forward the pending write onto a matching operand
  // port. Suppressed in reset because that write cannot commit.
  always_comb begin
    hit1       = rst_n && commit && (read_reg1 == write_reg);
    hit2       = rst_n && commit && (read_reg2 == write_reg);
    read_data1 = hit1 ? write_data : stored1;
    read_data2 = hit2 ? write_data : stored2;
  end
`else
  // Read-before-write: operand ports return the stored contents only.
  always_comb begin
    read_data1 = stored1;
    read_data2 = stored2;
  end
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// Bench for mips_register_file: directed vectors with literal expectations
// plus a per-cycle comparison against an array-based model. A second
// instance with a 4-bit counter shares the stimulus to exercise saturation.

module tb_mips_register_file;

  localparam logic [31:0] SP_RST = 32'h0000_3FFC;
  localparam logic [31:0] GP_RST = 32'h0000_1800;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  dbg_reg;

  logic [31:0] read_data1, read_data2, dbg_data, written_mask;
  logic [15:0] write_count;
  logic [31:0] b_rd1, b_rd2, b_dbg, b_mask;
  logic [3:0]  b_count;

  int checks = 0;
  int errors = 0;

  mips_register_file #(.DATA_W(32), .SP_RESET(SP_RST), .GP_RESET(GP_RST), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .dbg_reg(dbg_reg),
    .dbg_data(dbg_data), .written_mask(written_mask), .write_count(write_count)
  );

  mips_register_file #(.DATA_W(32), .SP_RESET(SP_RST), .GP_RESET(GP_RST), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(b_rd1), .read_data2(b_rd2), .dbg_reg(dbg_reg),
    .dbg_data(b_dbg), .written_mask(b_mask), .write_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model: plain array of architectural values, unbounded write tally.
  logic [31:0] m_regs [32];
  logic [31:0] m_mask;
  int          m_writes;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_regs[28] = GP_RST;
      m_regs[29] = SP_RST;
      m_mask     = 32'd0;
      m_writes   = 0;
    end else if (regWrite && write_reg != 5'd0) begin
      m_regs[write_reg]  = write_data;
      m_mask[write_reg]  = 1'b1;
      m_writes++;
    end
  end

  function automatic logic [31:0] exp_port(input logic [4:0] idx, input bit fwd);
    if (idx == 5'd0) return 32'd0;
    if (fwd && rst_n && regWrite && write_reg != 5'd0 && idx == write_reg) return write_data;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    chk("m_rd1",   read_data1,   exp_port(read_reg1, BYP));
    chk("m_rd2",   read_data2,   exp_port(read_reg2, BYP));
    chk("m_dbg",   dbg_data,     exp_port(dbg_reg, 1'b0));
    chk("m_mask",  written_mask, m_mask);
    chk("m_cnt",   {16'd0, write_count}, sat(m_writes, 16'hFFFF));
    chk("m4_rd1",  b_rd1,        exp_port(read_reg1, BYP));
    chk("m4_dbg",  b_dbg,        exp_port(dbg_reg, 1'b0));
    chk("m4_mask", b_mask,       m_mask);
    chk("m4_cnt",  {28'd0, b_count}, sat(m_writes, 15));
  end

  // One stimulus cycle: drive just after posedge, return at the next negedge.
  task automatic cyc(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    @(posedge clk);
    #1;
    regWrite = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; dbg_reg = d;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; regWrite = 1'b0; write_reg = 5'd0; write_data = 32'd0;
    read_reg1 = 5'd29; read_reg2 = 5'd28; dbg_reg = 5'd5;
    #1 rst_n = 1'b0;

    @(negedge clk);
    chk("rst_sp",    read_data1,   32'h0000_3FFC);
    chk("rst_gp",    read_data2,   32'h0000_1800);
    chk("rst_r5",    dbg_data,     32'd0);
    chk("rst_mask",  written_mask, 32'd0);
    chk("rst_cnt",   {16'd0, write_count}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 5'd8);
    chk("wr8_rd1",  read_data1,   32'hDEAD_BEEF);
    chk("wr8_mask", written_mask, 32'h0000_0100);
    chk("wr8_cnt",  {16'd0, write_count}, 32'd1);

    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    chk("r0_rd2", read_data2, 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    chk("r0_rd1",  read_data1,   32'd0);
    chk("r0_mask", written_mask, 32'h0000_0100);
    chk("r0_cnt",  {16'd0, write_count}, 32'd1);

    cyc(1'b1, 5'd9, 32'h1111_1111, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 5'd9, 32'h2222_2222, 5'd9, 5'd9, 5'd9);
    chk("rdw_rd1", read_data1, BYP ? 32'h2222_2222 : 32'h1111_1111);
    chk("rdw_dbg", dbg_data,   32'h1111_1111);
    cyc(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 5'd9);
    chk("rdw_after", read_data1, 32'h2222_2222);
    chk("rdw_dbg2",  dbg_data,   32'h2222_2222);

    cyc(1'b1, 5'd9, 32'h2222_2222, 5'd9, 5'd0, 5'd9);
    cyc(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 5'd9);
    chk("same_cnt",  {16'd0, write_count}, 32'd4);
    chk("same_mask", written_mask, 32'h0000_0300);

    for (int i = 0; i < 20; i++) cyc(1'b1, 5'd3, 32'(i + 1), 5'd3, 5'd0, 5'd3);
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd3);
    chk("sat4_cnt",  {28'd0, b_count}, 32'h0000_000F);
    chk("sat16_cnt", {16'd0, write_count}, 32'd24);
    chk("sat_r3",    read_data1, 32'd20);
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'd3, 32'(100 + i), 5'd3, 5'd0, 5'd3);
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd3);
    chk("sat4_hold",  {28'd0, b_count}, 32'h0000_000F);
    chk("sat16_more", {16'd0, write_count}, 32'd27);

    cyc(1'b1, 5'd5, 32'h0000_0055, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 5'd29, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'd0, 5'd29, 5'd28, 5'd5);
    chk("pre_sp", read_data1, 32'h1234_5678);
    chk("pre_r5", dbg_data,   32'h0000_0055);

    #1 rst_n = 1'b0;
    #1;
    chk("mid_sp",   read_data1,   32'h0000_3FFC);
    chk("mid_gp",   read_data2,   32'h0000_1800);
    chk("mid_r5",   dbg_data,     32'd0);
    chk("mid_mask", written_mask, 32'd0);
    chk("mid_cnt",  {16'd0, write_count}, 32'd0);
    chk("mid_cnt4", {28'd0, b_count}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(1'b1, 5'd12, 32'hABCD_0000, 5'd12, 5'd0, 5'd12);
    #4 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; regWrite = 1'b0;
    @(negedge clk);
    chk("rstw_r12",  read_data1,   32'd0);
    chk("rstw_mask", written_mask, 32'd0);
    chk("rstw_cnt",  {16'd0, write_count}, 32'd0);

    cyc(1'b1, 5'd12, 32'hABCD_0000, 5'd12, 5'd0, 5'd12);
    cyc(1'b0, 5'd0, 32'd0, 5'd12, 5'd0, 5'd12);
    chk("post_r12",  read_data1,   32'hABCD_0000);
    chk("post_mask", written_mask, 32'h0000_1000);
    chk("post_cnt",  {16'd0, write_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
